// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: cell encodings, controller states, win-line table
// and small board helpers, used by the board controller and the move selector.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    CPU   = 2'd0,
    HUMAN = 2'd1,
    EMPTY = 2'd2
  } cell_t;

  typedef enum logic [2:0] {
    WAIT_HUMAN,
    CHECK_H,
    WAIT_CPU,
    APPLY_CPU,
    CHECK_C,
    DONE
  } state_t;

  localparam int          NUM_CELLS   = 9;
  localparam logic [3:0]  LAST_CELL   = 4'd8;
  localparam logic [3:0]  FULL_COUNT  = 4'd9;
  localparam logic [17:0] BOARD_EMPTY = {9{2'b10}};

  // Entry l holds the three cell indices of line l as {c2, c1, c0}.
  localparam logic [7:0][11:0] WIN_LINES = {
    {4'd6, 4'd4, 4'd2},
    {4'd8, 4'd4, 4'd0},
    {4'd8, 4'd5, 4'd2},
    {4'd7, 4'd4, 4'd1},
    {4'd6, 4'd3, 4'd0},
    {4'd8, 4'd7, 4'd6},
    {4'd5, 4'd4, 4'd3},
    {4'd2, 4'd1, 4'd0}
  };

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] c;
    c = EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i)) c = b[2*i +: 2];
    end
    return c;
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] idx,
                                           input logic [1:0] mark);
    logic [17:0] r;
    r = b;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i)) r[2*i +: 2] = mark;
    end
    return r;
  endfunction

  // Returns 4'hF when no cell is empty; set_cell then leaves the board untouched.
  function automatic logic [3:0] lowest_empty(input logic [17:0] b);
    logic [3:0] r;
    r = 4'hF;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (b[2*i +: 2] == EMPTY) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/game_board_ctrl_if.sv
// Handshake and board bus between the game controller (slave) and the
// player/move-selector side (master).
interface game_board_ctrl_if;
  logic        new_game;
  logic        player_valid;
  logic [3:0]  player_pos;
  logic        player_ready;
  logic [3:0]  cpu_pos;
  logic        cpu_req;
  logic [17:0] board;
  logic        game_over;
  logic [1:0]  winner;
  logic        move_err;
  logic        cpu_fault;

  modport master (
    output new_game, player_valid, player_pos, cpu_pos,
    input  player_ready, cpu_req, board, game_over, winner, move_err, cpu_fault
  );

  modport slave (
    input  new_game, player_valid, player_pos, cpu_pos,
    output player_ready, cpu_req, board, game_over, winner, move_err, cpu_fault
  );
endinterface

// File: rtl/game_board_ctrl_line_detect.sv
// Combinational detector: high when any of the eight win lines is fully
// occupied by the given mark.
module line_detect
  import tictactoe_pkg::*;
(
  input  logic [17:0] board,
  input  cell_t       mark,
  output logic        o_any_line
);

  always_comb begin
    o_any_line = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((cell_at(board, WIN_LINES[l][3:0])  == mark) &&
          (cell_at(board, WIN_LINES[l][7:4])  == mark) &&
          (cell_at(board, WIN_LINES[l][11:8]) == mark))
        o_any_line = 1'b1;
    end
  end

endmodule

// File: rtl/game_board_ctrl.sv
// Tic-tac-toe board controller: validates human moves, paces the CPU move
// selector, corrects illegal CPU moves and detects win/draw.
module game_board_ctrl
  import tictactoe_pkg::*;
#(
  parameter int CPU_SETTLE = 2,
  parameter bit CPU_FIRST  = 1'b0
) (
  input logic              clock,
  input logic              reset,
  game_board_ctrl_if.slave bus
);

  localparam state_t     START_STATE = (CPU_FIRST == 1'b1) ? WAIT_CPU : WAIT_HUMAN;
  localparam logic [3:0] SETTLE_LOAD = 4'(CPU_SETTLE - 1);

  state_t      r_state;
  logic [17:0] r_board;
  logic [3:0]  r_move_cnt;
  logic [3:0]  r_settle;
  logic [3:0]  r_cpu_pos;
  logic [1:0]  r_winner;
  logic        r_move_err;
  logic        r_cpu_fault;

  logic        w_human_line;
  logic        w_cpu_line;
  logic        w_player_ok;
  logic        w_cpu_ok;
  logic [3:0]  w_lowest_empty;
  logic [3:0]  w_cpu_target;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= FULL_COUNT) ? FULL_COUNT : c + 4'd1;
  endfunction

  line_detect u_human_line (
    .board      (r_board),
    .mark       (HUMAN),
    .o_any_line (w_human_line)
  );

  line_detect u_cpu_line (
    .board      (r_board),
    .mark       (CPU),
    .o_any_line (w_cpu_line)
  );

  assign w_player_ok    = (bus.player_pos <= LAST_CELL) &&
                          (cell_at(r_board, bus.player_pos) == EMPTY);
  assign w_cpu_ok       = (r_cpu_pos <= LAST_CELL) &&
                          (cell_at(r_board, r_cpu_pos) == EMPTY);
  assign w_lowest_empty = lowest_empty(r_board);
  // An illegal selector answer falls back to the first free cell.
  assign w_cpu_target   = w_cpu_ok ? r_cpu_pos : w_lowest_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= START_STATE;
      r_board     <= BOARD_EMPTY;
      r_move_cnt  <= 4'd0;
      r_settle    <= 4'd0;
      r_cpu_pos   <= 4'd0;
      r_winner    <= EMPTY;
      r_move_err  <= 1'b0;
      r_cpu_fault <= 1'b0;
    end else if (bus.new_game) begin
      // Restart wins over any move offered in the same cycle.
      r_state     <= START_STATE;
      r_board     <= BOARD_EMPTY;
      r_move_cnt  <= 4'd0;
      r_settle    <= (CPU_FIRST == 1'b1) ? SETTLE_LOAD : 4'd0;
      r_winner    <= EMPTY;
      r_move_err  <= 1'b0;
      r_cpu_fault <= 1'b0;
    end else begin
      r_move_err <= 1'b0;
      case (r_state)
        WAIT_HUMAN: begin
          if (bus.player_valid) begin
            if (w_player_ok) begin
              r_board    <= set_cell(r_board, bus.player_pos, HUMAN);
              r_move_cnt <= sat_inc(r_move_cnt);
              r_state    <= CHECK_H;
            end else begin
              r_move_err <= 1'b1;
            end
          end
        end
        CHECK_H: begin
          if (w_human_line) begin
            r_winner <= HUMAN;
            r_state  <= DONE;
          end else if (r_move_cnt == FULL_COUNT) begin
            r_winner <= EMPTY;
            r_state  <= DONE;
          end else begin
            r_settle <= SETTLE_LOAD;
            r_state  <= WAIT_CPU;
          end
        end
        WAIT_CPU: begin
          // The selector's answer is only trusted on the last settle cycle.
          if (r_settle == 4'd0) begin
            r_cpu_pos <= bus.cpu_pos;
            r_state   <= APPLY_CPU;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        APPLY_CPU: begin
          r_board    <= set_cell(r_board, w_cpu_target, CPU);
          r_move_cnt <= sat_inc(r_move_cnt);
          if (!w_cpu_ok) r_cpu_fault <= 1'b1;
          r_state    <= CHECK_C;
        end
        CHECK_C: begin
          if (w_cpu_line) begin
            r_winner <= CPU;
            r_state  <= DONE;
          end else if (r_move_cnt == FULL_COUNT) begin
            r_winner <= EMPTY;
            r_state  <= DONE;
          end else begin
            r_state <= WAIT_HUMAN;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= START_STATE;
        end
      endcase
    end
  end

  assign bus.player_ready = (r_state == WAIT_HUMAN);
  assign bus.cpu_req      = (r_state == WAIT_CPU);
  assign bus.game_over    = (r_state == DONE);
  assign bus.board        = r_board;
  assign bus.winner       = r_winner;
  assign bus.move_err     = r_move_err;
  assign bus.cpu_fault    = r_cpu_fault;

endmodule

// File: tb/tb_game_board_ctrl.sv
// Bench for game_board_ctrl with CPU_SETTLE=3: scripted games from a vector
// table with a board scoreboard, plus hand-written rejection/restart/reset cases.
module tb_game_board_ctrl;
  import tictactoe_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  game_board_ctrl_if bus ();

  game_board_ctrl #(
    .CPU_SETTLE (3),
    .CPU_FIRST  (1'b0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          restart;
    bit          is_cpu;
    logic [3:0]  pos;
    logic [3:0]  decoy;
    logic [17:0] board;
    logic [1:0]  winner;
    bit          over;
    bit          fault;
  } vec_t;

  typedef struct {
    logic [17:0] board;
    bit          fault;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[18];

  function automatic logic [17:0] bd(input string s);
    logic [17:0] r;
    byte c;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      c = s.getc(i);
      if (c == "H")      r[2*i +: 2] = 2'b01;
      else if (c == "C") r[2*i +: 2] = 2'b00;
      else               r[2*i +: 2] = 2'b10;
    end
    return r;
  endfunction

  function automatic vec_t mkv(input bit restart, input bit is_cpu, input int pos,
                               input int decoy, input string b, input logic [1:0] w,
                               input bit over, input bit fault);
    vec_t v;
    v.restart = restart;
    v.is_cpu  = is_cpu;
    v.pos     = 4'(pos);
    v.decoy   = 4'(decoy);
    v.board   = bd(b);
    v.winner  = w;
    v.over    = over;
    v.fault   = fault;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_sb(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=none expected=entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_board"}, 32'(bus.board), 32'(e.board));
      chk({nm, "_fault"}, 32'(bus.cpu_fault), 32'(e.fault));
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.player_ready && k < 30) begin
      @(negedge clock);
      k++;
    end
    chk("player_ready_wait", 32'(bus.player_ready), 32'd1);
  endtask

  task automatic pulse_new_game(input bit with_move);
    bus.new_game     = 1'b1;
    bus.player_valid = with_move;
    bus.player_pos   = 4'd5;
    @(negedge clock);
    bus.new_game     = 1'b0;
    bus.player_valid = 1'b0;
    chk("ng_board",  32'(bus.board), 32'(bd(".........")));
    chk("ng_ready",  32'(bus.player_ready), 32'd1);
    chk("ng_err",    32'(bus.move_err), 32'd0);
    chk("ng_fault",  32'(bus.cpu_fault), 32'd0);
    chk("ng_winner", 32'(bus.winner), 32'd2);
    chk("ng_over",   32'(bus.game_over), 32'd0);
    sbq.delete();
  endtask

  // Drives a decoy on cpu_pos for the first two request cycles, the real move on the third.
  task automatic cpu_turn(input logic [3:0] pos, input logic [3:0] decoy);
    int n;
    int k;
    n = 0;
    k = 0;
    while (!bus.cpu_req && k < 30) begin
      @(negedge clock);
      k++;
    end
    while (bus.cpu_req && n < 10) begin
      n++;
      bus.cpu_pos = (n < 3) ? decoy : pos;
      @(negedge clock);
    end
    chk("cpu_req_cycles", 32'(n), 32'd3);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    exp_t e;
    if (v.restart) pulse_new_game(1'b0);
    e.board = v.board;
    e.fault = v.fault;
    if (!v.is_cpu) begin
      wait_ready();
      bus.player_valid = 1'b1;
      bus.player_pos   = v.pos;
      sbq.push_back(e);
      @(negedge clock);
      bus.player_valid = 1'b0;
      compare_sb($sformatf("v%0d_human", idx));
      chk($sformatf("v%0d_err", idx), 32'(bus.move_err), 32'd0);
      chk($sformatf("v%0d_over_early", idx), 32'(bus.game_over), 32'd0);
    end else begin
      sbq.push_back(e);
      cpu_turn(v.pos, v.decoy);
      @(negedge clock);
      compare_sb($sformatf("v%0d_cpu", idx));
    end
    @(negedge clock);
    chk($sformatf("v%0d_over", idx), 32'(bus.game_over), 32'(v.over));
    chk($sformatf("v%0d_winner", idx), 32'(bus.winner), 32'(v.winner));
  endtask

  task automatic illegal_move(input logic [3:0] pos, input string b);
    bus.player_valid = 1'b1;
    bus.player_pos   = pos;
    @(negedge clock);
    bus.player_valid = 1'b0;
    chk($sformatf("ill%0d_err", pos),   32'(bus.move_err), 32'd1);
    chk($sformatf("ill%0d_board", pos), 32'(bus.board), 32'(bd(b)));
    chk($sformatf("ill%0d_ready", pos), 32'(bus.player_ready), 32'd1);
    @(negedge clock);
    chk($sformatf("ill%0d_err_end", pos), 32'(bus.move_err), 32'd0);
    chk($sformatf("ill%0d_ready2", pos),  32'(bus.player_ready), 32'd1);
  endtask

  initial begin
    // Game A: human takes the top row.
    vecs[0]  = mkv(0, 0, 0, 0, "H........", 2'd2, 0, 0);
    vecs[1]  = mkv(0, 1, 3, 5, "H..C.....", 2'd2, 0, 0);
    vecs[2]  = mkv(0, 0, 1, 0, "HH.C.....", 2'd2, 0, 0);
    vecs[3]  = mkv(0, 1, 4, 6, "HH.CC....", 2'd2, 0, 0);
    vecs[4]  = mkv(0, 0, 2, 0, "HHHCC....", 2'd1, 1, 0);
    // Game B: selector answers an occupied cell and gets corrected.
    vecs[5]  = mkv(1, 0, 0, 0, "H........", 2'd2, 0, 0);
    vecs[6]  = mkv(0, 1, 0, 5, "HC.......", 2'd2, 0, 1);
    vecs[7]  = mkv(0, 0, 4, 0, "HC..H....", 2'd2, 0, 1);
    vecs[8]  = mkv(0, 1, 8, 5, "HC..H...C", 2'd2, 0, 1);
    // Game C: nine moves ending in a draw.
    vecs[9]  = mkv(1, 0, 0, 0, "H........", 2'd2, 0, 0);
    vecs[10] = mkv(0, 1, 4, 1, "H...C....", 2'd2, 0, 0);
    vecs[11] = mkv(0, 0, 8, 0, "H...C...H", 2'd2, 0, 0);
    vecs[12] = mkv(0, 1, 1, 2, "HC..C...H", 2'd2, 0, 0);
    vecs[13] = mkv(0, 0, 7, 0, "HC..C..HH", 2'd2, 0, 0);
    vecs[14] = mkv(0, 1, 6, 3, "HC..C.CHH", 2'd2, 0, 0);
    vecs[15] = mkv(0, 0, 2, 0, "HCH.C.CHH", 2'd2, 0, 0);
    vecs[16] = mkv(0, 1, 5, 3, "HCH.CCCHH", 2'd2, 0, 0);
    vecs[17] = mkv(0, 0, 3, 0, "HCHHCCCHH", 2'd2, 1, 0);

    bus.new_game     = 1'b0;
    bus.player_valid = 1'b0;
    bus.player_pos   = 4'd0;
    bus.cpu_pos      = 4'd0;
    reset            = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_board",  32'(bus.board), 32'(bd(".........")));
    chk("rst_ready",  32'(bus.player_ready), 32'd1);
    chk("rst_req",    32'(bus.cpu_req), 32'd0);
    chk("rst_over",   32'(bus.game_over), 32'd0);
    chk("rst_winner", 32'(bus.winner), 32'd2);
    chk("rst_err",    32'(bus.move_err), 32'd0);
    chk("rst_fault",  32'(bus.cpu_fault), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i <= 8; i++) apply_vec(vecs[i], i);

    illegal_move(4'd4, "HC..H...C");
    illegal_move(4'd9, "HC..H...C");
    chk("fault_sticky", 32'(bus.cpu_fault), 32'd1);

    pulse_new_game(1'b1);
    @(negedge clock);
    chk("ng_move_dropped", 32'(bus.board), 32'(bd(".........")));
    chk("ng_move_no_err",  32'(bus.move_err), 32'd0);

    for (int i = 9; i <= 17; i++) apply_vec(vecs[i], i);

    bus.player_valid = 1'b1;
    bus.player_pos   = 4'd0;
    @(negedge clock);
    bus.player_valid = 1'b0;
    chk("done_err",    32'(bus.move_err), 32'd0);
    chk("done_board",  32'(bus.board), 32'(bd("HCHHCCCHH")));
    chk("done_over",   32'(bus.game_over), 32'd1);
    chk("done_winner", 32'(bus.winner), 32'd2);

    pulse_new_game(1'b0);
    bus.player_valid = 1'b1;
    bus.player_pos   = 4'd4;
    @(negedge clock);
    bus.player_valid = 1'b0;
    @(negedge clock);
    chk("pre_rst_req", 32'(bus.cpu_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_board", 32'(bus.board), 32'(bd(".........")));
    chk("arst_ready", 32'(bus.player_ready), 32'd1);
    chk("arst_req",   32'(bus.cpu_req), 32'd0);
    chk("arst_err",   32'(bus.move_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", 32'(bus.player_ready), 32'd1);
    chk("post_rst_board", 32'(bus.board), 32'(bd(".........")));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
